fuel_pump_fsm: RTL and testbench



---
 rtl/fuel_pump_fsm.sv | 141 ++++++++++++++
 tb/tb_fuel_pump_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fuel_pump_fsm.sv
// rtl/fuel_pump_fsm.sv - anti-theft fuel-pump interlock: ignition plus timed hidden combination
module fuel_pump_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter int COMBO_HOLD  = 4,
  parameter int ARM_WINDOW  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ignition_on,
  input  logic hidden_switch,
  input  logic brake_pressed,
  output logic fuel_pump_on
);

  // A one-cycle hold still needs a 1-bit counter so the compare stays legal.
  localparam int HOLD_W = (COMBO_HOLD > 1) ? $clog2(COMBO_HOLD) : 1;
  localparam int WIN_W  = (ARM_WINDOW > 1) ? $clog2(ARM_WINDOW) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(COMBO_HOLD - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(ARM_WINDOW - 1);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_WAIT    = 2'd1,
    S_RUN     = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  // Bit 0 of each chain is the newest capture; the top bit feeds the FSM.
  logic [SYNC_STAGES-1:0] ign_sync_q;
  logic [SYNC_STAGES-1:0] hid_sync_q;
  logic [SYNC_STAGES-1:0] brk_sync_q;

  logic ign_s;
  logic hid_s;
  logic brk_s;
  logic combo_s;

  state_t            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic              pump_q;

  // Saturating next values for the two counters.
  logic [HOLD_W-1:0] hold_inc_d;
  logic [WIN_W-1:0]  win_inc_d;

  // Synchronizer chains for the three asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ign_sync_q <= '0;
      hid_sync_q <= '0;
      brk_sync_q <= '0;
    end else begin
      ign_sync_q <= SYNC_STAGES'({ign_sync_q, ignition_on});
      hid_sync_q <= SYNC_STAGES'({hid_sync_q, hidden_switch});
      brk_sync_q <= SYNC_STAGES'({brk_sync_q, brake_pressed});
    end
  end

  assign ign_s   = ign_sync_q[SYNC_STAGES-1];
  assign hid_s   = hid_sync_q[SYNC_STAGES-1];
  assign brk_s   = brk_sync_q[SYNC_STAGES-1];
  assign combo_s = hid_s & brk_s;

  // Counter increments that stop at their terminal value instead of wrapping.
  always_comb begin
    hold_inc_d = hold_cnt_q;
    win_inc_d  = win_cnt_q;
    if (hold_cnt_q != HOLD_LAST) begin
      hold_inc_d = hold_cnt_q + 1'b1;
    end
    if (win_cnt_q != WIN_LAST) begin
      win_inc_d = win_cnt_q + 1'b1;
    end
  end

  // Interlock FSM; the pump enable is registered alongside the state so the relay never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_OFF;
      hold_cnt_q <= '0;
      win_cnt_q  <= '0;
      pump_q     <= 1'b0;
    end else if (!ign_s) begin
      // Ignition off overrides every other event, including a pending unlock.
      state_q    <= S_OFF;
      hold_cnt_q <= '0;
      win_cnt_q  <= '0;
      pump_q     <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          // The first WAIT edge is where an already-held combination starts counting.
          state_q    <= S_WAIT;
          hold_cnt_q <= '0;
          win_cnt_q  <= '0;
          pump_q     <= 1'b0;
        end
        S_WAIT: begin
          if (combo_s && (hold_cnt_q == HOLD_LAST)) begin
            // Completing the hold on the last window cycle still unlocks.
            state_q    <= S_RUN;
            hold_cnt_q <= '0;
            win_cnt_q  <= '0;
            pump_q     <= 1'b1;
          end else if (win_cnt_q == WIN_LAST) begin
            state_q    <= S_LOCKOUT;
            hold_cnt_q <= '0;
            win_cnt_q  <= '0;
            pump_q     <= 1'b0;
          end else begin
            state_q    <= S_WAIT;
            win_cnt_q  <= win_inc_d;
            hold_cnt_q <= combo_s ? hold_inc_d : '0;
            pump_q     <= 1'b0;
          end
        end
        S_RUN: begin
          // Switch and brake are don't-cares once running.
          state_q <= S_RUN;
          pump_q  <= 1'b1;
        end
        S_LOCKOUT: begin
          // Only an ignition cycle leaves lockout.
          state_q <= S_LOCKOUT;
          pump_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_OFF;
          hold_cnt_q <= '0;
          win_cnt_q  <= '0;
          pump_q     <= 1'b0;
        end
      endcase
    end
  end

  assign fuel_pump_on = pump_q;

endmodule

// File: tb/tb_fuel_pump_fsm.sv
// tb/tb_fuel_pump_fsm.sv - self-checking bench for fuel_pump_fsm
module tb_fuel_pump_fsm;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int WIN  = 64;

  logic clk;
  logic rst;
  logic ign;
  logic hid;
  logic brk;
  logic pump;

  int checks;
  int errors;

  // Reference: the FSM sees each raw level SYNC captures later; a session
  // starts on the first edge with ignition seen, then counts cycles waited
  // and the current streak of consecutive combination cycles.
  logic [1:0] pipe[$];
  bit active;
  bit unlocked;
  bit locked;
  int waited;
  int streak;
  logic exp_pump;

  fuel_pump_fsm #(
    .SYNC_STAGES(SYNC),
    .COMBO_HOLD (HOLD),
    .ARM_WINDOW (WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ignition_on  (ign),
    .hidden_switch(hid),
    .brake_pressed(brk),
    .fuel_pump_on (pump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [1:0] seen;
    if (!rst) begin
      pipe.delete();
      for (int k = 0; k < SYNC; k++) pipe.push_back(2'b00);
      active   = 0;
      unlocked = 0;
      locked   = 0;
      waited   = 0;
      streak   = 0;
    end else begin
      seen = pipe.pop_front();
      pipe.push_back({ign, hid & brk});
      if (!seen[1]) begin
        active   = 0;
        unlocked = 0;
        locked   = 0;
      end else if (!active) begin
        active = 1;
        waited = 0;
        streak = 0;
      end else if (!unlocked && !locked) begin
        waited++;
        streak = seen[0] ? streak + 1 : 0;
        if (seen[0] && streak == HOLD) unlocked = 1;
        else if (waited == WIN) locked = 1;
      end
    end
    exp_pump = unlocked;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("pump_vs_model", pump, exp_pump);
    end
  endtask

  task automatic set_combo(input logic v);
    hid = v;
    brk = v;
  endtask

  initial begin
    int  n;
    bit  got;
    bit  want;
    checks = 0;
    errors = 0;
    exp_pump = 1'b0;

    // Reset with every input high.
    rst = 1'b0;
    ign = 1'b1;
    set_combo(1'b1);
    tick(2);
    chk("reset_pump", pump, 1'b0);

    // After release, inputs still high: ignition seen at edge 3, combo counts from edge 4.
    rst = 1'b1;
    tick(6);
    chk("post_reset_not_yet", pump, 1'b0);
    tick(1);
    chk("post_reset_unlock", pump, 1'b1);
    ign = 1'b0;
    set_combo(1'b0);
    tick(5);

    // Normal unlock latency and ignition-off latency.
    ign = 1'b1;
    tick(4);
    set_combo(1'b1);
    tick(1);
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      n++;
      got = pump;
    end
    chk_int("unlock_latency", n, 5);
    set_combo(1'b0);
    ign = 1'b0;
    tick(1);
    n = 0;
    got = 1;
    for (int i = 0; i < 20 && got; i++) begin
      tick(1);
      n++;
      got = pump;
    end
    chk_int("off_latency", n, 2);
    tick(10);
    chk("stays_off", pump, 1'b0);

    // Broken hold: 3 on, 1 off, 4 on.
    ign = 1'b1;
    tick(4);
    for (int t = 1; t <= 10; t++) begin
      set_combo((t <= 3) || (t >= 5 && t <= 8));
      tick(1);
      if (t == 9) chk("broken_hold_early", pump, 1'b0);
      if (t == 10) chk("broken_hold_unlock", pump, 1'b1);
    end
    ign = 1'b0;
    set_combo(1'b0);
    tick(5);

    // Timeout into lockout, combination ignored, recovery by ignition cycle.
    ign = 1'b1;
    tick(2 + WIN + 2);
    set_combo(1'b1);
    tick(10);
    chk("lockout_ignores_combo", pump, 1'b0);
    set_combo(1'b0);
    ign = 1'b0;
    tick(4);
    ign = 1'b1;
    tick(4);
    set_combo(1'b1);
    tick(6);
    chk("lockout_recovery", pump, 1'b1);
    ign = 1'b0;
    set_combo(1'b0);
    tick(5);

    // Boundary: combination completing on the 64th WAIT edge wins; one cycle later loses.
    for (int b = 0; b < 2; b++) begin
      ign = 1'b1;
      for (int t = 1; t <= 70; t++) begin
        set_combo(t >= 62 + b);
        tick(1);
        if (t == 67) chk("window_boundary", pump, (b == 0));
      end
      ign = 1'b0;
      set_combo(1'b0);
      tick(5);
    end

    // Pump independent of switches once running; reset drops it at once.
    ign = 1'b1;
    tick(3);
    set_combo(1'b1);
    tick(6);
    chk("run_entered", pump, 1'b1);
    set_combo(1'b0);
    tick(6);
    chk("run_ignores_release", pump, 1'b1);
    rst = 1'b0;
    tick(1);
    chk("reset_in_run", pump, 1'b0);
    rst = 1'b1;
    tick(5);

    // Randomized switch activity against the reference.
    want = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) ign = ~ign;
      if ($urandom_range(0, 5) == 0) want = ~want;
      if ($urandom_range(0, 11) == 0) begin
        hid = $urandom_range(0, 1);
        brk = ~hid;
      end else begin
        set_combo(want);
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      else rst = 1'b1;
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
